// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   Sequential ripple adder: adds two WIDTH-bit operands plus a carry-in,
//   CHUNK bits per clock, over NCHUNK = WIDTH/CHUNK cycles. A start/busy/done
//   handshake frames each operation. The results stay in output registers
//   until the next completion.
//
// Parameters
//   WIDTH     operand/sum width (>= 1)
//   CHUNK     bits added per cycle (WIDTH must be a multiple of CHUNK)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled only while busy=0
//   a, b      operands, captured on an accepted start
//   cin       carry-in, captured on an accepted start
//   busy      operation in progress
//   done      one-cycle pulse: sum/cout/overflow were just updated
//   sum       registered (a + b + cin) mod 2^WIDTH
//   cout      registered unsigned carry-out
//   overflow  registered two's-complement overflow
// -----------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    // Elaboration fails if the parameters cannot be split into whole chunks
    generate
        if ((WIDTH < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("multicycle_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] wsum_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] wsum_next_s;
    logic             ovf_next_s;

    // Carry into the MSB XOR carry out of it, written in terms of the operand
    // MSBs and the sum MSB so that the internal carry need not be kept.
    function automatic logic calc_overflow(input logic a_msb, input logic b_msb,
                                           input logic s_msb, input logic c_out);
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    // One CHUNK-bit add per cycle: the slice selected by k plus the running carry
    always_comb begin
        a_chunk_s   = a_r[int'(k_r) * CHUNK +: CHUNK];
        b_chunk_s   = b_r[int'(k_r) * CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        wsum_next_s = wsum_r;
        wsum_next_s[int'(k_r) * CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        ovf_next_s  = calc_overflow(a_r[WIDTH-1], b_r[WIDTH-1],
                                    wsum_next_s[WIDTH-1], chunk_sum_s[CHUNK]);
    end

    // Control FSM, working registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            wsum_r   <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            k_r      <= K_ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        wsum_r  <= {WIDTH{1'b0}};
                        k_r     <= K_ZERO;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    wsum_r  <= wsum_next_s;
                    carry_r <= chunk_sum_s[CHUNK];
                    if (k_r == K_LAST) begin
                        // Last chunk: publish the result and release the handshake
                        sum      <= wsum_next_s;
                        cout     <= chunk_sum_s[CHUNK];
                        overflow <= ovf_next_s;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        k_r      <= K_ZERO;
                        state_r  <= ST_IDLE;
                    end else begin
                        done     <= 1'b0;
                        k_r      <= k_r + K_ONE;
                        state_r  <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    k_r     <= K_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
module tb_multicycle_adder;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generation, 10 ns period
    always #5 clk = ~clk;

    // DUT 0: WIDTH=32, CHUNK=8
    logic        start0, cin0, busy0, done0, cout0, ovf0;
    logic [31:0] a0, b0, sum0;
    // DUT 1: WIDTH=8, CHUNK=8
    logic        start1, cin1, busy1, done1, cout1, ovf1;
    logic [7:0]  a1, b1, sum1;
    // DUT 2: WIDTH=32, CHUNK=4
    logic        start2, cin2, busy2, done2, cout2, ovf2;
    logic [31:0] a2, b2, sum2;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0));

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

    multicycle_adder #(.WIDTH(32), .CHUNK(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          dut;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cur   = 0;

    logic        m_busy, m_done, m_cout, m_ovf;
    logic [31:0] m_sum;

    // Output view of the DUT currently under test
    always_comb begin
        m_busy = busy0; m_done = done0; m_sum = sum0; m_cout = cout0; m_ovf = ovf0;
        case (cur)
            1: begin
                m_busy = busy1; m_done = done1; m_sum = {24'h000000, sum1};
                m_cout = cout1; m_ovf = ovf1;
            end
            2: begin
                m_busy = busy2; m_done = done2; m_sum = sum2;
                m_cout = cout2; m_ovf = ovf2;
            end
            default: ;
        endcase
    end

    function automatic int nch(input int dut);
        case (dut)
            1:       return 1;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int wid(input int dut);
        return (dut == 1) ? 8 : 32;
    endfunction

    // Reference: plain integer addition plus the signed-overflow definition
    function automatic exp_t model(input int dut, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
        exp_t        r;
        int          w    = wid(dut);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] t    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, cin};
        r.sum  = t[31:0] & mask[31:0];
        r.cout = t[w];
        r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic set_in(input int dut, input logic st, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
        case (dut)
            1:       begin start1 = st; a1 = a[7:0]; b1 = b[7:0]; cin1 = cin; end
            2:       begin start2 = st; a2 = a; b2 = b; cin2 = cin; end
            default: begin start0 = st; a0 = a; b0 = b; cin0 = cin; end
        endcase
    endtask

    task automatic set_start(input int dut, input logic st);
        case (dut)
            1:       start1 = st;
            2:       start2 = st;
            default: start0 = st;
        endcase
    endtask

    // Called on the negedge where start was driven; returns on the done negedge
    task automatic wait_done(input int dut, input bit scramble, input bit chk_stable,
                             input logic [31:0] stable, output int edges,
                             output bit timed_out);
        edges     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            edges++;
            if (m_done) begin
                timed_out = 1'b0;
                set_start(dut, 1'b0);
                break;
            end
            chk("busy_during_run", {63'd0, m_busy}, 64'd1);
            if (chk_stable) chk("sum_hold", {32'd0, m_sum}, {32'd0, stable});
            if (scramble) set_in(dut, 1'b1, $urandom, $urandom, 1'($urandom));
            else          set_start(dut, 1'b0);
        end
        if (timed_out) begin
            set_start(dut, 1'b0);
            chk("done_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic finish_op(input int dut, input int edges, input bit timed_out);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            if (!timed_out) begin
                chk("sum",      {32'd0, m_sum},  {32'd0, e.sum});
                chk("cout",     {63'd0, m_cout}, {63'd0, e.cout});
                chk("overflow", {63'd0, m_ovf},  {63'd0, e.ovf});
                chk("latency",  64'(edges - 1),  64'(nch(dut)));
                chk("busy_at_done", {63'd0, m_busy}, 64'd0);
            end
        end
    endtask

    task automatic run_op(input int dut, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input exp_t e);
        int edges;
        bit to;
        @(negedge clk);
        cur = dut;
        set_in(dut, 1'b1, a, b, cin);
        sb.push_back(e);
        wait_done(dut, 1'b0, 1'b0, 32'd0, edges, to);
        finish_op(dut, edges, to);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, m_done}, 64'd0);
    endtask

    // Hard stop in case the sequence below ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        bit   to;
        exp_t e;
        logic [31:0] ra, rb;
        logic        rc;

        rst_n = 1'b0;
        set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
        set_in(2, 1'b0, 32'd0, 32'd0, 1'b0);

        vecs[0]  = '{0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1]  = '{0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4]  = '{0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[5]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{0, 32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[7]  = '{1, 32'h00000080, 32'h00000080, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{1, 32'h0000007F, 32'h00000001, 1'b0, 32'h00000080, 1'b0, 1'b1};
        vecs[9]  = '{1, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{2, 32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0};

        // Reset state of every instance
        #12;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            chk("rst_sum",  {32'd0, m_sum},  64'd0);
            chk("rst_cout", {63'd0, m_cout}, 64'd0);
            chk("rst_ovf",  {63'd0, m_ovf},  64'd0);
            chk("rst_busy", {63'd0, m_busy}, 64'd0);
            chk("rst_done", {63'd0, m_done}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            e.sum = vecs[i].s; e.cout = vecs[i].co; e.ovf = vecs[i].ov;
            run_op(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].cin, e);
        end

        // start held high with operands changing while busy
        @(negedge clk);
        cur = 0;
        set_in(0, 1'b1, 32'h00000010, 32'h00000020, 1'b0);
        e.sum = 32'h00000030; e.cout = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        wait_done(0, 1'b1, 1'b0, 32'd0, edges, to);
        finish_op(0, edges, to);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, m_done}, 64'd0);

        // Back-to-back: new start presented in the done cycle
        @(negedge clk);
        set_in(0, 1'b1, 32'h00000100, 32'h00000200, 1'b0);
        e.sum = 32'h00000300; e.cout = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        wait_done(0, 1'b0, 1'b0, 32'd0, edges, to);
        finish_op(0, edges, to);
        set_in(0, 1'b1, 32'd5, 32'd7, 1'b0);
        e.sum = 32'd12; e.cout = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        wait_done(0, 1'b0, 1'b1, 32'h00000300, edges, to);
        finish_op(0, edges, to);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, m_done}, 64'd0);

        // Reset between E2 and E3 of an operation
        @(negedge clk);
        set_in(0, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0);
        @(negedge clk);
        set_start(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_sum",  {32'd0, m_sum},  64'd0);
        chk("midrst_cout", {63'd0, m_cout}, 64'd0);
        chk("midrst_ovf",  {63'd0, m_ovf},  64'd0);
        chk("midrst_busy", {63'd0, m_busy}, 64'd0);
        chk("midrst_done", {63'd0, m_done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {63'd0, m_done}, 64'd0);
        end
        e.sum = 32'd7; e.cout = 1'b0; e.ovf = 1'b0;
        run_op(0, 32'd3, 32'd4, 1'b0, e);

        // Random operations on the 32/4 instance
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            run_op(2, ra, rb, rc, model(2, ra, rb, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
